// File: rtl/centroid_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the centroid divide scheduler.
package centroid_pkg;

    localparam int CX_W   = 11;
    localparam int CY_W   = 10;
    localparam int CX_MAX = 2047;
    localparam int CY_MAX = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/centroid_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, W cycles from load to done.
// o_quotient/o_remainder carry the final result combinationally while o_done is high.
module centroid_serial_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [W:0]       w_shift_rem;
    logic [W:0]       w_diff;
    logic             w_bit;
    logic [W-1:0]     w_rem_next;
    logic [W-1:0]     w_quo_next;
    logic             w_last;

    // Partial remainder stays below the divisor, so the shifted value fits in W+1 bits.
    always_comb begin
        w_shift_rem = {r_rem, r_quo[W-1]};
        w_diff      = w_shift_rem - {1'b0, r_div};
        w_bit       = ~w_diff[W];
        w_rem_next  = w_bit ? w_diff[W-1:0] : w_shift_rem[W-1:0];
        w_quo_next  = {r_quo[W-2:0], w_bit};
        w_last      = r_busy && (r_cnt == CNT_W'(W - 1));
    end

    assign o_done      = w_last;
    assign o_quotient  = w_quo_next;
    assign o_remainder = w_rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/centroid_div_sched.sv
// Centroid scheduler: divides frame sums by pixel count for X then Y on one shared serial divider.
// Define CENTROID_ROUND_EN to round to nearest instead of truncating.
module centroid_div_sched
    import centroid_pkg::*;
#(
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] sum_x,
    input  logic [SUM_W-1:0] sum_y,
    input  logic [SUM_W-1:0] count,
    output logic [CX_W-1:0]  cx,
    output logic [CY_W-1:0]  cy,
    output logic             valid,
    output logic             busy,
    output logic             empty,
    output logic             overrun
);

    state_t           r_state;
    logic [SUM_W-1:0] r_sum_y;
    logic [SUM_W-1:0] r_count;
    logic [SUM_W-1:0] r_qx;

    logic             w_accept;
    logic             w_load_x;
    logic             w_load_y;
    logic             w_div_load;
    logic [SUM_W-1:0] w_dividend_x;
    logic [SUM_W-1:0] w_dividend_y;
    logic [SUM_W-1:0] w_div_dividend;
    logic [SUM_W-1:0] w_div_divisor;
    logic             w_div_done;
    logic [SUM_W-1:0] w_quotient;
    logic [SUM_W-1:0] w_div_rem_unused;

`ifdef CENTROID_ROUND_EN
    // Adding half the divisor before flooring gives round-half-up; clamp instead of wrapping.
    function automatic logic [SUM_W-1:0] f_round_sat(input logic [SUM_W-1:0] i_sum,
                                                     input logic [SUM_W-1:0] i_cnt);
        logic [SUM_W:0] v_total;
        v_total = {1'b0, i_sum} + {1'b0, (i_cnt >> 1)};
        return v_total[SUM_W] ? '1 : v_total[SUM_W-1:0];
    endfunction

    assign w_dividend_x = f_round_sat(sum_x, count);
    assign w_dividend_y = f_round_sat(sum_y, count);
`else
    assign w_dividend_x = sum_x;
    assign w_dividend_y = sum_y;
`endif

    // The DONE cycle accepts a new frame exactly like IDLE does.
    assign w_accept       = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_load_x       = w_accept && (count != '0);
    assign w_load_y       = (r_state == DIV_X) && w_div_done;
    assign w_div_load     = w_load_x || w_load_y;
    assign w_div_dividend = w_load_x ? w_dividend_x : r_sum_y;
    assign w_div_divisor  = w_load_x ? count : r_count;

    centroid_serial_div #(
        .W (SUM_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_div_load),
        .i_dividend  (w_div_dividend),
        .i_divisor   (w_div_divisor),
        .o_done      (w_div_done),
        .o_quotient  (w_quotient),
        .o_remainder (w_div_rem_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sum_y <= '0;
            r_count <= '0;
            r_qx    <= '0;
            cx      <= '0;
            cy      <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            empty   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= 1'b0;
            empty   <= 1'b0;
            overrun <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_load_x) begin
                        r_sum_y <= w_dividend_y;
                        r_count <= count;
                        r_state <= DIV_X;
                        busy    <= 1'b1;
                    end else begin
                        empty   <= w_accept;
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                DIV_X: begin
                    overrun <= start;
                    if (w_div_done) begin
                        r_qx    <= w_quotient;
                        r_state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    overrun <= start;
                    if (w_div_done) begin
                        cx      <= (r_qx > SUM_W'(CX_MAX)) ? CX_W'(CX_MAX) : r_qx[CX_W-1:0];
                        cy      <= (w_quotient > SUM_W'(CY_MAX)) ? CY_W'(CY_MAX)
                                                                 : w_quotient[CY_W-1:0];
                        valid   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
